fiber_bank_arbiter: RTL and testbench
=====================================

FIBER_BANK_ARBITER -- requirements
Module: fiber_bank_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters sharing one fiberBank port.
REQ-002 SHALL have parameter ADDR_WIDTH, default 64: request address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 16: write/read data width.
REQ-004 SHALL have parameter OP_WIDTH, default 2: opcode width (0 read, 1 write, 2 fetch, 3 consume).
REQ-005 SHALL have parameter DEPTH, default 4: max outstanding bank requests, power of two.
REQ-006 SHALL use one clock; reset is synchronous and active-high: i_clk  in  1  clock, rising edge; i_rst  in  1  synchronous active-high reset.
REQ-007 SHALL have i_req_valid  in  NUM_REQ  per-requester request valid.
REQ-008 SHALL have o_req_ready  out  NUM_REQ  per-requester accept, one-hot or zero.
REQ-009 SHALL have i_req_op  in  NUM_REQ*OP_WIDTH, i_req_addr  in  NUM_REQ*ADDR_WIDTH, i_req_data  in  NUM_REQ*DATA_WIDTH: packed request fields, requester k at slice k.
REQ-010 SHALL have o_bank_valid  out  1, i_bank_ready  in  1, o_bank_op  out  OP_WIDTH, o_bank_addr  out  ADDR_WIDTH, o_bank_data  out  DATA_WIDTH: bank request port.
REQ-011 SHALL have i_rsp_valid  in  1, i_rsp_data  in  DATA_WIDTH: in-order bank responses.
REQ-012 SHALL have o_rsp_valid  out  NUM_REQ (one-hot), o_rsp_data  out  DATA_WIDTH: routed response.
REQ-013 SHALL have o_err  out  1: sticky unexpected-response flag.
REQ-014 SHALL have o_grant_cnt  out  NUM_REQ*16: per-requester grant counters (see Configuration).

Function
REQ-015 SHALL grant, each cycle, the first valid requester at or after round-robin pointer rr (wrapping NUM_REQ-1 -> 0).
REQ-016 SHALL assert o_req_ready[g] only for granted g, and only when output register empty or draining this cycle (o_bank_valid & i_bank_ready) and outstanding count < DEPTH.
REQ-017 SHALL on accept (valid & ready) load op/addr/data into output register; o_bank_valid high the next cycle (1-cycle latency).
REQ-018 SHALL hold o_bank_valid and all o_bank_* stable until i_bank_ready; back-to-back accept allowed in the drain cycle.
REQ-019 SHALL advance rr to g+1 (mod NUM_REQ) on accept only; rr unchanged otherwise.
REQ-020 SHALL push granted ID into a DEPTH-entry ID FIFO on accept; outstanding = FIFO occupancy.
REQ-021 SHALL on i_rsp_valid with FIFO non-empty pop head ID h, drive o_rsp_valid = 1<<h and o_rsp_data = i_rsp_data in the same cycle (combinational).
REQ-022 SHALL on simultaneous accept and response push and pop in one cycle, occupancy unchanged; accept permitted at occupancy DEPTH-1 and not at DEPTH even if a pop occurs.
REQ-023 SHALL on i_rsp_valid with FIFO empty drive o_rsp_valid = 0, set o_err, leave state unchanged.
REQ-024 SHALL wrap FIFO read/write pointers modulo DEPTH.

Reset
REQ-025 SHALL on i_rst clear rr=0, FIFO empty, output register invalid, o_bank_valid=0, o_req_ready=0, o_rsp_valid=0, o_err=0, o_grant_cnt=0; bank fields 0.
REQ-026 SHALL on reset mid-operation discard in-flight requests and outstanding IDs; responses after reset set o_err.

Configuration
REQ-027 SHALL with macro FIBER_BANK_ARB_STATS_EN defined increment o_grant_cnt slice k by 1 on each accept of requester k, saturating at 16'hFFFF.
REQ-028 SHALL without FIBER_BANK_ARB_STATS_EN tie o_grant_cnt to 0 and instantiate no counter registers; all other behaviour identical.

Verification
REQ-029 SHALL cover: all 4 requesters valid continuously, i_bank_ready=1 -> grants 0,1,2,3,0 on consecutive cycles, each o_bank_valid one cycle after accept.
REQ-030 SHALL cover: requesters 1 and 3 valid, rr=2 -> 3 granted first, then 1.
REQ-031 SHALL cover: i_bank_ready=0 for 5 cycles with addr 0x40 pending -> o_bank_addr stays 0x40, no further o_req_ready.
REQ-032 SHALL cover: 4 accepts, no responses -> o_req_ready=0; one i_rsp_valid with data 0x1234 -> o_rsp_valid=0001 (first ID 0), data 0x1234, accept resumes next cycle.
REQ-033 SHALL cover: i_rsp_valid after reset with FIFO empty -> o_rsp_valid=0, o_err=1 until next i_rst.
REQ-034 SHALL cover: with FIBER_BANK_ARB_STATS_EN, 70000 grants to requester 2 -> o_grant_cnt[2]=16'hFFFF; without macro -> 0.

Source files
------------

// File: rtl/fiber_bank_arbiter.sv
// Round-robin arbiter that funnels NUM_REQ requesters into one fiberBank port and routes in-order responses back by ID.
// Optional per-requester grant counters are enabled by defining FIBER_BANK_ARB_STATS_EN.
module fiber_bank_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 16,
  parameter int OP_WIDTH   = 2,
  parameter int DEPTH      = 4
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic [NUM_REQ-1:0]             i_req_valid,
  output logic [NUM_REQ-1:0]             o_req_ready,
  input  logic [NUM_REQ*OP_WIDTH-1:0]    i_req_op,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  i_req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  i_req_data,
  output logic                           o_bank_valid,
  input  logic                           i_bank_ready,
  output logic [OP_WIDTH-1:0]            o_bank_op,
  output logic [ADDR_WIDTH-1:0]          o_bank_addr,
  output logic [DATA_WIDTH-1:0]          o_bank_data,
  input  logic                           i_rsp_valid,
  input  logic [DATA_WIDTH-1:0]          i_rsp_data,
  output logic [NUM_REQ-1:0]             o_rsp_valid,
  output logic [DATA_WIDTH-1:0]          o_rsp_data,
  output logic                           o_err,
  output logic [NUM_REQ*16-1:0]          o_grant_cnt
);

  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [ID_W-1:0]       rr_q;
  logic                  bank_valid_q;
  logic [OP_WIDTH-1:0]   bank_op_q;
  logic [ADDR_WIDTH-1:0] bank_addr_q;
  logic [DATA_WIDTH-1:0] bank_data_q;
  logic                  err_q;

  logic [ID_W-1:0]       id_mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      cnt_q;

  logic                  grant_found;
  logic [ID_W-1:0]       grant_id;
  logic                  accept;
  logic                  rsp_pop;
  logic [ID_W-1:0]       head_id;
  logic [ID_W-1:0]       rr_d;
  logic [PTR_W-1:0]      wr_ptr_d, rd_ptr_d;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    int idx;
    idx         = 0;
    grant_found = 1'b0;
    grant_id    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(rr_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!grant_found && i_req_valid[idx]) begin
        grant_found = 1'b1;
        grant_id    = ID_W'(idx);
      end
    end
  end

  // A slot opens when the output register is empty or drains this cycle; pops never free a slot early.
  assign accept  = !i_rst && grant_found && (!bank_valid_q || i_bank_ready)
                   && (cnt_q < CNT_W'(DEPTH));
  assign rsp_pop = !i_rst && i_rsp_valid && (cnt_q != '0);
  assign head_id = id_mem_q[rd_ptr_q];

  assign rr_d     = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
  assign wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
  assign rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);

  assign o_req_ready  = accept  ? (NUM_REQ'(1) << grant_id) : '0;
  assign o_rsp_valid  = rsp_pop ? (NUM_REQ'(1) << head_id)  : '0;
  assign o_rsp_data   = i_rsp_data;
  assign o_bank_valid = bank_valid_q;
  assign o_bank_op    = bank_op_q;
  assign o_bank_addr  = bank_addr_q;
  assign o_bank_data  = bank_data_q;
  assign o_err        = err_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rr_q         <= '0;
      bank_valid_q <= 1'b0;
      bank_op_q    <= '0;
      bank_addr_q  <= '0;
      bank_data_q  <= '0;
      err_q        <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
    end else begin
      if (accept) begin
        rr_q         <= rr_d;
        bank_valid_q <= 1'b1;
        bank_op_q    <= i_req_op[grant_id*OP_WIDTH +: OP_WIDTH];
        bank_addr_q  <= i_req_addr[grant_id*ADDR_WIDTH +: ADDR_WIDTH];
        bank_data_q  <= i_req_data[grant_id*DATA_WIDTH +: DATA_WIDTH];
        wr_ptr_q     <= wr_ptr_d;
      end else if (i_bank_ready) begin
        bank_valid_q <= 1'b0;
      end

      if (rsp_pop) rd_ptr_q <= rd_ptr_d;

      case ({accept, rsp_pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase

      if (i_rsp_valid && (cnt_q == '0)) err_q <= 1'b1;
    end
  end

  // NOTE: the ID storage has no reset; entries are only read once the occupancy count marks them written.
  always_ff @(posedge i_clk) begin
    if (accept) id_mem_q[wr_ptr_q] <= grant_id;
  end

`ifdef FIBER_BANK_ARB_STATS_EN
  logic [15:0] grant_cnt_q [NUM_REQ];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < NUM_REQ; k++) grant_cnt_q[k] <= '0;
    end else if (accept && (grant_cnt_q[grant_id] != 16'hFFFF)) begin
      grant_cnt_q[grant_id] <= grant_cnt_q[grant_id] + 16'd1;
    end
  end

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_cnt_out
    assign o_grant_cnt[k*16 +: 16] = grant_cnt_q[k];
  end
`else
  assign o_grant_cnt = '0;
`endif

endmodule

// File: tb/tb_fiber_bank_arbiter.sv
// Directed self-checking bench for fiber_bank_arbiter (default parameters).
// Inputs change just after a rising edge; outputs are compared mid-cycle before the next edge.
module tb_fiber_bank_arbiter;

  localparam int NUM_REQ = 4;
  localparam int AW      = 64;
  localparam int DW      = 16;
  localparam int OW      = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*OW-1:0] req_op;
  logic [NUM_REQ*AW-1:0] req_addr;
  logic [NUM_REQ*DW-1:0] req_data;
  logic                  bank_valid;
  logic                  bank_ready;
  logic [OW-1:0]         bank_op;
  logic [AW-1:0]         bank_addr;
  logic [DW-1:0]         bank_data;
  logic                  rsp_valid_in;
  logic [DW-1:0]         rsp_data_in;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [DW-1:0]         rsp_data;
  logic                  err;
  logic [NUM_REQ*16-1:0] grant_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fiber_bank_arbiter dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_op     (req_op),
    .i_req_addr   (req_addr),
    .i_req_data   (req_data),
    .o_bank_valid (bank_valid),
    .i_bank_ready (bank_ready),
    .o_bank_op    (bank_op),
    .o_bank_addr  (bank_addr),
    .o_bank_data  (bank_data),
    .i_rsp_valid  (rsp_valid_in),
    .i_rsp_data   (rsp_data_in),
    .o_rsp_valid  (rsp_valid),
    .o_rsp_data   (rsp_data),
    .o_err        (err),
    .o_grant_cnt  (grant_cnt)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_defaults();
    req_valid    = '0;
    bank_ready   = 1'b1;
    rsp_valid_in = 1'b0;
    rsp_data_in  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      req_op  [k*OW +: OW] = OW'(k);
      req_addr[k*AW +: AW] = 64'h100 + 64'(k);
      req_data[k*DW +: DW] = 16'hD0 + 16'(k);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_defaults();
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    set_defaults();
    step();
    step();
    settle();
    check("rst_bank_valid", 64'(bank_valid), 64'd0);
    check("rst_req_ready",  64'(req_ready),  64'd0);
    check("rst_rsp_valid",  64'(rsp_valid),  64'd0);
    check("rst_err",        64'(err),        64'd0);
    check("rst_grant_cnt",  grant_cnt,       64'd0);
    check("rst_bank_addr",  bank_addr,       64'd0);
    rst = 1'b0;

    // All four requesters valid: grants 0,1,2,3,0 with responses keeping occupancy at 1.
    req_valid = 4'b1111;
    settle();
    check("rr0_ready", 64'(req_ready),  64'b0001);
    check("rr0_bval",  64'(bank_valid), 64'd0);
    step();
    for (int c = 1; c <= 4; c++) begin
      rsp_valid_in = 1'b1;
      rsp_data_in  = 16'hA000 + 16'(c);
      settle();
      check($sformatf("rr%0d_ready", c), 64'(req_ready), 64'(4'b0001 << (c % 4)));
      check($sformatf("rr%0d_bval", c),  64'(bank_valid), 64'd1);
      check($sformatf("rr%0d_addr", c),  bank_addr, 64'h100 + 64'(c - 1));
      check($sformatf("rr%0d_rsp", c),   64'(rsp_valid), 64'(4'b0001 << (c - 1)));
      check($sformatf("rr%0d_rdata", c), 64'(rsp_data), 64'(16'hA000 + 16'(c)));
      step();
    end
    req_valid   = '0;
    rsp_data_in = 16'hBEEF;
    settle();
    check("rr5_addr",  bank_addr,       64'h100);
    check("rr5_data",  64'(bank_data),  64'hD0);
    check("rr5_op",    64'(bank_op),    64'd0);
    check("rr5_rsp",   64'(rsp_valid),  64'b0001);
    step();
    rsp_valid_in = 1'b0;
    settle();
    check("rr6_bval",  64'(bank_valid), 64'd0);
    check("rr6_err",   64'(err),        64'd0);

    // Pointer at 2 with requesters 1 and 3 valid: 3 wins, then 1.
    do_reset();
    req_valid = 4'b0010;
    settle();
    check("p2_setup_ready", 64'(req_ready), 64'b0010);
    step();
    req_valid    = 4'b1010;
    rsp_valid_in = 1'b1;
    rsp_data_in  = 16'h5555;
    settle();
    check("p2_first_ready", 64'(req_ready), 64'b1000);
    check("p2_first_rsp",   64'(rsp_valid), 64'b0010);
    step();
    settle();
    check("p2_second_ready", 64'(req_ready), 64'b0010);
    check("p2_second_addr",  bank_addr,      64'h103);
    check("p2_second_op",    64'(bank_op),   64'd3);
    check("p2_second_rsp",   64'(rsp_valid), 64'b1000);
    step();
    req_valid = '0;
    settle();
    check("p2_third_addr", bank_addr,      64'h101);
    check("p2_third_rsp",  64'(rsp_valid), 64'b0010);
    step();
    rsp_valid_in = 1'b0;

    // Bank stalls five cycles with address 0x40 held.
    do_reset();
    req_addr[0 +: AW] = 64'h40;
    req_valid  = 4'b0001;
    bank_ready = 1'b0;
    settle();
    check("stall_accept", 64'(req_ready), 64'b0001);
    step();
    req_addr[0 +: AW] = 64'h99;
    for (int c = 0; c < 5; c++) begin
      settle();
      check($sformatf("stall%0d_bval", c),  64'(bank_valid), 64'd1);
      check($sformatf("stall%0d_addr", c),  bank_addr,       64'h40);
      check($sformatf("stall%0d_ready", c), 64'(req_ready),  64'd0);
      step();
    end
    bank_ready = 1'b1;
    settle();
    check("stall_drain_ready", 64'(req_ready), 64'b0001);
    step();
    req_valid = '0;
    settle();
    check("stall_next_addr", bank_addr, 64'h99);
    step();

    // Fill all DEPTH slots, then one response frees a slot for the following cycle.
    do_reset();
    req_valid = 4'b1111;
    for (int c = 0; c < 4; c++) begin
      settle();
      check($sformatf("full%0d_ready", c), 64'(req_ready), 64'(4'b0001 << c));
      step();
    end
    settle();
    check("full_blocked0", 64'(req_ready), 64'd0);
    step();
    settle();
    check("full_blocked1", 64'(req_ready), 64'd0);
`ifndef FIBER_BANK_ARB_STATS_EN
    check("nostats_cnt", grant_cnt, 64'd0);
`endif
    rsp_valid_in = 1'b1;
    rsp_data_in  = 16'h1234;
    settle();
    check("full_rsp_valid", 64'(rsp_valid), 64'b0001);
    check("full_rsp_data",  64'(rsp_data),  64'h1234);
    check("full_pop_ready", 64'(req_ready), 64'd0);
    step();
    rsp_valid_in = 1'b0;
    settle();
    check("full_resume", 64'(req_ready), 64'b0001);
    step();

    // Reset with IDs outstanding; a later response finds the FIFO empty.
    req_valid = '0;
    do_reset();
    rsp_valid_in = 1'b1;
    rsp_data_in  = 16'h7777;
    settle();
    check("err_rsp_valid", 64'(rsp_valid), 64'd0);
    check("err_pre",       64'(err),       64'd0);
    step();
    rsp_valid_in = 1'b0;
    for (int c = 0; c < 3; c++) begin
      settle();
      check($sformatf("err_sticky%0d", c), 64'(err), 64'd1);
      step();
    end
    settle();
    check("err_bval", 64'(bank_valid), 64'd0);
    do_reset();
    settle();
    check("err_cleared", 64'(err), 64'd0);

`ifdef FIBER_BANK_ARB_STATS_EN
    // 70000 grants to requester 2; a response each cycle keeps one ID outstanding.
    req_valid = 4'b0100;
    settle();
    check("stats_first_ready", 64'(req_ready), 64'b0100);
    step();
    settle();
    check("stats_one", 64'(grant_cnt[32 +: 16]), 64'd1);
    rsp_valid_in = 1'b1;
    for (int c = 1; c < 70000; c++) step();
    rsp_valid_in = 1'b0;
    req_valid    = '0;
    settle();
    check("stats_sat",    64'(grant_cnt[32 +: 16]), 64'hFFFF);
    check("stats_other0", 64'(grant_cnt[0 +: 16]),  64'd0);
    check("stats_err",    64'(err),                 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
